// File: rtl/au_lead_det_iter_if.sv
// Handshake bundle for au_lead_det_iter: input word/mode channel and result channel.
// The master drives stimulus and accepts results; the slave is the detector.
interface au_lead_det_iter_if #(
  parameter int WIDTH = 32
) ();
  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z;
  logic [PW-1:0]    pos;
  logic             no_det;

  modport master (
    output in_valid, a, mode, out_ready,
    input  in_ready, out_valid, z, pos, no_det
  );

  modport slave (
    input  in_valid, a, mode, out_ready,
    output in_ready, out_valid, z, pos, no_det
  );
endinterface

// File: rtl/au_lead_det_iter.sv
// Chunk-iterative leading-digit detector: scans one CHUNK-bit slice per cycle from the MSB.
// Optional macro AU_LEAD_DET_OVERLAP_EN lets a new job be accepted on the result handoff cycle.
module au_lead_det_iter #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic               clk,
  input logic               rst,
  au_lead_det_iter_if.slave bus
);
  localparam int NCHK = (CHUNK > 0) ? (WIDTH + CHUNK - 1) / CHUNK : 1;
  localparam int PW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int MW   = (NCHK > 1) ? $clog2(NCHK) : 1;
  localparam int TOT  = NCHK * CHUNK;

  generate
    if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_params
      $fatal(1, "au_lead_det_iter: illegal parameters WIDTH=%0d CHUNK=%0d", WIDTH, CHUNK);
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [MW-1:0]    m_q, m_d;
  logic [TOT-1:0]   sh_q, sh_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic             nd_q, nd_d;

  logic             in_ready_w;
  logic             accept;
  logic             last;
  logic             hit;
  logic [31:0]      hit_off;
  logic [31:0]      pos_calc;
  logic [TOT-1:0]   load_w;

  // Word is left-aligned in a chunk-multiple shifter; zero padding below bit 0 can never hit.
  always_comb begin
    load_w = '0;
    load_w[TOT-1 -: WIDTH] = bus.mode ? bus.a : ~bus.a;
  end

  always_comb begin
    hit     = 1'b0;
    hit_off = '0;
    for (int unsigned j = 0; j < CHUNK; j++) begin
      if (!hit && sh_q[TOT-1-j]) begin
        hit     = 1'b1;
        hit_off = j;
      end
    end
  end

  assign last     = (32'(m_q) == 32'(NCHK - 1));
  assign pos_calc = 32'(WIDTH - 1) - 32'(m_q) * 32'(CHUNK) - hit_off;

  always_comb begin
    in_ready_w = 1'b0;
    if (!rst) begin
      if (state_q == S_IDLE) begin
        in_ready_w = 1'b1;
      end
`ifdef AU_LEAD_DET_OVERLAP_EN
      else if (state_q == S_DONE) begin
        in_ready_w = bus.out_ready;
      end
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    sh_d    = sh_q;
    z_d     = z_q;
    pos_d   = pos_q;
    nd_d    = nd_q;
    accept  = bus.in_valid && in_ready_w;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          sh_d    = load_w;
          m_d     = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (hit) begin
          z_d     = WIDTH'(1) << pos_calc;
          pos_d   = PW'(pos_calc);
          nd_d    = 1'b0;
          state_d = S_DONE;
        end else if (last) begin
          z_d     = '0;
          pos_d   = '0;
          nd_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          m_d  = m_q + 1'b1;
          sh_d = sh_q << CHUNK;
        end
      end
      S_DONE: begin
        // accept can only be true here when overlap is enabled
        if (bus.out_ready) begin
          if (accept) begin
            sh_d    = load_w;
            m_d     = '0;
            state_d = S_SCAN;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      sh_q    <= '0;
      z_q     <= '0;
      pos_q   <= '0;
      nd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      sh_q    <= sh_d;
      z_q     <= z_d;
      pos_q   <= pos_d;
      nd_q    <= nd_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = !rst && (state_q == S_DONE);
  assign bus.z         = rst ? '0 : z_q;
  assign bus.pos       = rst ? '0 : pos_q;
  assign bus.no_det    = rst ? 1'b0 : nd_q;
endmodule

// File: tb/tb_au_lead_det_iter.sv
// Directed bench for au_lead_det_iter (32/8 and 13/4 instances) with a queue scoreboard.
module tb_au_lead_det_iter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

`ifdef AU_LEAD_DET_OVERLAP_EN
  localparam int GAP = 0;
`else
  localparam int GAP = 1;
`endif

  au_lead_det_iter_if #(.WIDTH(32)) bus0 ();
  au_lead_det_iter_if #(.WIDTH(13)) bus1 ();

  au_lead_det_iter #(.WIDTH(32), .CHUNK(8)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  au_lead_det_iter #(.WIDTH(13), .CHUNK(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    logic [31:0] z;
    logic [31:0] pos;
    logic        nd;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  logic sel   = 1'b0;
  logic ordy  = 1'b1;

  logic        cur_in_ready, cur_out_valid, cur_nd;
  logic [31:0] cur_z, cur_pos;

  always_comb begin
    cur_in_ready  = sel ? bus1.in_ready  : bus0.in_ready;
    cur_out_valid = sel ? bus1.out_valid : bus0.out_valid;
    cur_nd        = sel ? bus1.no_det    : bus0.no_det;
    cur_z         = sel ? 32'(bus1.z)    : bus0.z;
    cur_pos       = sel ? 32'(bus1.pos)  : 32'(bus0.pos);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [31:0] z, input logic [31:0] pos, input logic nd, input int lat);
    exp_t e;
    e.z = z; e.pos = pos; e.nd = nd; e.lat = lat;
    sb.push_back(e);
  endtask

  function automatic exp_t model32(input logic md, input logic [31:0] av);
    exp_t e;
    e.z = '0; e.pos = '0; e.nd = 1'b1; e.lat = 5;
    for (int i = 31; i >= 0; i--) begin
      if (e.nd && av[i] == md) begin
        e.nd  = 1'b0;
        e.pos = i;
        e.z   = 32'(1) << i;
        e.lat = (31 - i) / 8 + 2;
      end
    end
    return e;
  endfunction

  task automatic drive(input logic v, input logic md, input logic [31:0] av);
    bus0.in_valid = v && !sel;
    bus1.in_valid = v && sel;
    bus0.mode = md;
    bus1.mode = md;
    bus0.a = av;
    bus1.a = av[12:0];
  endtask

  task automatic set_ordy(input logic r);
    ordy = r;
    bus0.out_ready = r;
    bus1.out_ready = r;
  endtask

  // Returns in the cycle after the accept edge (cycle T+1).
  task automatic send(input string tag, input logic md, input logic [31:0] av);
    int k = 0;
    drive(1'b1, md, av);
    while (!cur_in_ready && k < 50) begin
      @(posedge clk); #1; k++;
    end
    chk({tag, ".accept"}, 32'(cur_in_ready), 32'd1);
    @(posedge clk); #1;
    drive(1'b0, md, av);
  endtask

  task automatic collect(input string tag);
    exp_t e;
    int n = 1;
    while (!cur_out_valid && n < 64) begin
      @(posedge clk); #1; n++;
    end
    e = sb.pop_front();
    chk({tag, ".valid"}, 32'(cur_out_valid), 32'd1);
    chk({tag, ".lat"}, n, e.lat);
    chk({tag, ".z"}, cur_z, e.z);
    chk({tag, ".pos"}, cur_pos, e.pos);
    chk({tag, ".nd"}, 32'(cur_nd), 32'(e.nd));
  endtask

  task automatic job(input string tag, input logic md, input logic [31:0] av);
    send(tag, md, av);
    collect(tag);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] oz, opos, rv;
    logic        ond, md;
    exp_t        e;
    int          cyc, hcyc, acyc, seen;

    rst = 1'b1;
    drive(1'b0, 1'b0, '0);
    set_ordy(1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst.in_ready0", 32'(bus0.in_ready), 32'd0);
    chk("rst.out_valid0", 32'(bus0.out_valid), 32'd0);
    chk("rst.z0", bus0.z, 32'd0);
    chk("rst.pos0", 32'(bus0.pos), 32'd0);
    chk("rst.nd0", 32'(bus0.no_det), 32'd0);
    chk("rst.in_ready1", 32'(bus1.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("idle.in_ready0", 32'(bus0.in_ready), 32'd1);
    chk("idle.in_ready1", 32'(bus1.in_ready), 32'd1);
    @(posedge clk); #1;

    push(32'h0000_8000, 32'd15, 1'b0, 4);
    job("t1", 1'b0, 32'hFFFF_7FFF);
    push(32'h0, 32'd0, 1'b1, 5);
    job("t2", 1'b0, 32'hFFFF_FFFF);
    push(32'h8000_0000, 32'd31, 1'b0, 2);
    job("t3a", 1'b1, 32'h8000_0000);
    push(32'h0, 32'd0, 1'b1, 5);
    job("t3b", 1'b1, 32'h0000_0000);

    for (int i = 0; i < 6; i++) begin
      rv = $urandom >> $urandom_range(0, 31);
      md = 1'(i % 2);
      sb.push_back(model32(md, rv));
      job("rand", md, rv);
    end

    // Result held under backpressure; in_valid pulses must be ignored.
    set_ordy(1'b0);
    push(32'h0080_0000, 32'd23, 1'b0, 3);
    send("t4", 1'b1, 32'h00F0_0000);
    collect("t4");
    oz = cur_z; opos = cur_pos; ond = cur_nd;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, $urandom);
      @(posedge clk); #1;
      chk("t4.hold_valid", 32'(cur_out_valid), 32'd1);
      chk("t4.hold_z", cur_z, oz);
      chk("t4.hold_pos", cur_pos, opos);
      chk("t4.hold_nd", 32'(cur_nd), 32'(ond));
      chk("t4.hold_in_ready", 32'(cur_in_ready), 32'd0);
    end
    drive(1'b0, 1'b0, '0);
    set_ordy(1'b1);
    @(posedge clk); #1;
    chk("t4.released", 32'(cur_out_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("t4.no_phantom", 32'(cur_out_valid), 32'd0);
    chk("t4.idle_ready", 32'(cur_in_ready), 32'd1);

    // Reset during SCAN discards the job.
    send("t5", 1'b0, 32'hFFFF_FFFF);
    rst = 1'b1;
    #1;
    chk("t5.rst_in_ready", 32'(cur_in_ready), 32'd0);
    chk("t5.rst_out_valid", 32'(cur_out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("t5.ready_after", 32'(cur_in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (cur_out_valid) seen++;
    end
    chk("t5.discarded", seen, 0);
    push(32'h0000_0100, 32'd8, 1'b0, 4);
    job("t5.next", 1'b1, 32'h0000_01FF);

    sel = 1'b1;
    #1;
    push(32'h0000_0001, 32'd0, 1'b0, 5);
    job("t6a", 1'b1, 32'h0000_0001);
    push(32'h0000_1000, 32'd12, 1'b0, 2);
    job("t6b", 1'b1, 32'h0000_1000);
    push(32'h0, 32'd0, 1'b1, 5);
    job("t6c", 1'b0, 32'h0000_1FFF);
    push(32'h0000_0020, 32'd5, 1'b0, 3);
    job("t6d", 1'b0, 32'h0000_1FDF);
    sel = 1'b0;
    #1;

    // Back-to-back jobs: gap between result handoff and next accept.
    push(32'h8000_0000, 32'd31, 1'b0, 2);
    send("t7.job1", 1'b1, 32'h8000_0000);
    drive(1'b1, 1'b1, 32'h0000_0001);
    cyc = 0; hcyc = -1; acyc = -1;
    while (acyc < 0 && cyc < 20) begin
      if (hcyc < 0 && cur_out_valid && ordy) begin
        hcyc = cyc;
        e = sb.pop_front();
        chk("t7.job1_pos", cur_pos, e.pos);
        chk("t7.job1_z", cur_z, e.z);
      end
      if (cur_in_ready) acyc = cyc;
      @(posedge clk); #1;
      cyc++;
    end
    drive(1'b0, 1'b0, '0);
    chk("t7.gap", acyc - hcyc, GAP);
    push(32'h0000_0001, 32'd0, 1'b0, 5);
    collect("t7.job2");
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
